// File: rtl/wb_spi_bridge_master_if.sv
// wb_spi_bridge_master_if: Wishbone bundle between a local bus master and the SPI bridge
interface wb_spi_bridge_master_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_spi_bridge_master.sv
// wb_spi_bridge_master: turns each Wishbone access into a 72-bit command frame plus a poll frame over SPI
module wb_spi_bridge_master #(
  parameter int          CLK_DIV   = 4,
  parameter int          CS_GAP    = 16,
  parameter logic [31:0] POLL_ADDR = 32'h0000_0000
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_n_i,
  wb_spi_bridge_master_if.slave        wbs,
  output logic                         cs_n,
  output logic                         sclk,
  output logic                         mosi,
  input  logic                         miso
);
  localparam int              GW        = $clog2(CS_GAP + 1);
  localparam logic [GW-1:0]   GAP_MAX   = GW'(CS_GAP);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(CS_GAP - 1);
  localparam logic [7:0]      DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0]      HALF_LAST = 8'd144;
  typedef enum logic [2:0] {IDLE, CMD, GAP, POLL, RESP} state_t;
  state_t        state_q, state_d;
  logic [7:0]    div_q, div_d, half_q, half_d;
  logic          sclk_q, sclk_d, cs_n_q, cs_n_d, we_q, we_d, abort_q, abort_d;
  logic          ack_q, ack_d, err_q, err_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [71:0]   tx_q, tx_d;
  logic [65:0]   rx_q, rx_d;
  logic [31:0]   dat_q, dat_d;
  logic [1:0]    miso_q;
  logic          shifting, tick, frame_end, toggle, accept, gap_done, respond, rx_ok;
  assign shifting  = state_q == CMD || state_q == POLL;
  assign tick      = shifting && div_q == DIV_LAST;
  // 144 toggles make the 72 clocks; the 145th half-period is the trailing low before cs_n rises
  assign frame_end = tick && half_q == HALF_LAST;
  assign toggle    = tick && half_q != HALF_LAST;
  assign accept    = state_q == IDLE && wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q && !err_q && gap_q == GAP_MAX;
  assign gap_done  = state_q == GAP && gap_q == GAP_LAST;
  assign respond   = state_q == RESP && !abort_q && wbs.wbs_cyc_i;
  assign rx_ok     = rx_q[64] && !rx_q[65];
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      gap_q   <= GAP_MAX;
      tx_q    <= '0;
      rx_q    <= '0;
      dat_q   <= '0;
      miso_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      we_q    <= we_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dat_q   <= dat_d;
      miso_q  <= {miso_q[0], miso};
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? CMD : IDLE;
      CMD:     state_d = frame_end ? GAP : CMD;
      GAP:     state_d = gap_done ? POLL : GAP;
      POLL:    state_d = frame_end ? RESP : POLL;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    div_d   = tick || !shifting ? '0 : div_q + 8'd1;
    half_d  = !shifting ? '0 : tick ? half_q + 8'd1 : half_q;
    sclk_d  = toggle ? !sclk_q : sclk_q;
    cs_n_d  = accept || gap_done ? 1'b0 : frame_end ? 1'b1 : cs_n_q;
    tx_d    = accept ? {wbs.wbs_we_i, 3'b000, wbs.wbs_sel_i, wbs.wbs_adr_i, wbs.wbs_we_i ? wbs.wbs_dat_i : 32'h0}
            : gap_done ? {8'h00, POLL_ADDR, 32'h0}
            : toggle && sclk_q ? {tx_q[70:0], 1'b0} : tx_q;
    rx_d    = toggle && !sclk_q ? {rx_q[64:0], miso_q[1]} : rx_q;
    we_d    = accept ? wbs.wbs_we_i : we_q;
    abort_d = accept ? 1'b0 : state_q != IDLE && !wbs.wbs_cyc_i ? 1'b1 : abort_q;
    ack_d   = respond && rx_ok;
    err_d   = respond && !rx_ok;
    dat_d   = respond && rx_ok && !we_q ? rx_q[31:0] : dat_q;
    gap_d   = state_q == RESP || frame_end ? '0
            : state_q == GAP || (state_q == IDLE && gap_q != GAP_MAX) ? gap_q + 1'b1 : gap_q;
  end
  assign cs_n          = cs_n_q;
  assign sclk          = sclk_q;
  assign mosi          = tx_q[71];
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_err_o = err_q;
  assign wbs.wbs_dat_o = dat_q;
endmodule

// File: tb/tb_wb_spi_bridge_master.sv
// tb_wb_spi_bridge_master: scoreboard bench with an SPI slave model for default and fast-parameter bridges
module tb_wb_spi_bridge_master;
  localparam int DIV[2]  = '{4, 3};
  localparam int GAPC[2] = '{16, 5};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wb_spi_bridge_master_if ifa ();
  wb_spi_bridge_master_if ifb ();
  logic cs_a, sclk_a, mosi_a, cs_b, sclk_b, mosi_b;
  logic [1:0] miso_v;
  wb_spi_bridge_master dut_a (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs(ifa),
    .cs_n(cs_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_v[0])
  );
  wb_spi_bridge_master #(.CLK_DIV(3), .CS_GAP(5)) dut_b (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs(ifb),
    .cs_n(cs_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_v[1])
  );
  logic [1:0] cs_v, sclk_v, mosi_v, ack_v, err_v;
  logic [31:0] dat_v [2];
  assign cs_v   = {cs_b, cs_a};
  assign sclk_v = {sclk_b, sclk_a};
  assign mosi_v = {mosi_b, mosi_a};
  assign ack_v  = {ifb.wbs_ack_o, ifa.wbs_ack_o};
  assign err_v  = {ifb.wbs_err_o, ifa.wbs_err_o};
  assign dat_v[0] = ifa.wbs_dat_o;
  assign dat_v[1] = ifb.wbs_dat_o;
  typedef struct { int dut; logic [71:0] frame; } fr_t;
  typedef struct { int dut; logic is_ack; logic [31:0] dat; int t0; int lat; } rs_t;
  fr_t exp_fr[$];
  rs_t exp_rs[$];
  int n_chk = 0;
  int n_fail = 0;
  int cycle = 0;
  logic [71:0] resp_val [2];
  logic [31:0] dat_model [2] = '{32'h0, 32'h0};
  int frames_done [2] = '{0, 0};
  int resp_seen [2] = '{0, 0};
  int rises [2] = '{0, 0};
  int run [2], low_len [2], fidx [2];
  int hi_len [2] = '{1000, 1000};
  logic [71:0] cap [2], sh [2];
  logic cs_p [2], sclk_p [2], mosi_p [2];
  fr_t fe;
  rs_t re;
  always @(posedge clk) cycle <= cycle + 1;
  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // SPI slave model and line-protocol checker, sampled on the falling clock edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        cs_p[k] = 1'b1; sclk_p[k] = 1'b0; rises[k] = 0; fidx[k] = 0; miso_v[k] = 1'b0; hi_len[k]++;
      end else if (cs_p[k] && !cs_v[k]) begin
        check($sformatf("cs_gap%0d", k), 72'(hi_len[k] >= GAPC[k]), 72'd1);
        rises[k] = 0; run[k] = 1; low_len[k] = 1; cap[k] = '0;
        sh[k] = fidx[k][0] ? resp_val[k] : {8'($urandom), $urandom, $urandom};
        miso_v[k] = sh[k][71];
      end else if (!cs_p[k] && !cs_v[k]) begin
        low_len[k]++;
        if (sclk_v[k] != sclk_p[k]) begin
          check($sformatf("half_period%0d", k), 72'(run[k]), 72'(DIV[k]));
          run[k] = 1;
          if (sclk_v[k]) begin
            check($sformatf("mosi_stable%0d", k), mosi_v[k], mosi_p[k]);
            cap[k] = {cap[k][70:0], mosi_v[k]};
            rises[k]++;
          end else begin
            sh[k] = sh[k] << 1;
            miso_v[k] = sh[k][71];
          end
        end else run[k]++;
      end else if (!cs_p[k] && cs_v[k]) begin
        check($sformatf("tail_low%0d", k), 72'(run[k]), 72'(DIV[k]));
        check($sformatf("frame_len%0d", k), 72'(low_len[k]), 72'(145 * DIV[k]));
        check($sformatf("rises%0d", k), 72'(rises[k]), 72'd72);
        check($sformatf("frame_pending%0d", k), 72'(exp_fr.size() > 0), 72'd1);
        if (exp_fr.size() > 0) begin
          fe = exp_fr.pop_front();
          check("frame_dut", 72'(fe.dut), 72'(k));
          check($sformatf("frame%0d_%0d", k, fidx[k]), cap[k], fe.frame);
        end
        frames_done[k]++; fidx[k]++; hi_len[k] = 1;
      end else begin
        hi_len[k]++;
        check($sformatf("idle_sclk%0d", k), sclk_v[k], 1'b0);
      end
      cs_p[k] = cs_v[k]; sclk_p[k] = sclk_v[k]; mosi_p[k] = mosi_v[k];
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (ack_v[k] || err_v[k]) begin
          resp_seen[k]++;
          check("ack_err_exclusive", 72'(ack_v[k] && err_v[k]), 72'd0);
          check("resp_pending", 72'(exp_rs.size() > 0), 72'd1);
          if (exp_rs.size() > 0) begin
            re = exp_rs.pop_front();
            check("resp_dut", 72'(re.dut), 72'(k));
            check($sformatf("ack%0d", k), ack_v[k], re.is_ack);
            check($sformatf("err%0d", k), err_v[k], !re.is_ack);
            check($sformatf("dat%0d", k), dat_v[k], re.dat);
            if (re.lat >= 0) check($sformatf("latency%0d", k), 72'(cycle - re.t0), 72'(re.lat));
          end
        end
      end
    end
  end
  task automatic drive(input int k, input logic cyc, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (k == 0) begin
      ifa.wbs_cyc_i = cyc; ifa.wbs_stb_i = cyc; ifa.wbs_we_i = we;
      ifa.wbs_sel_i = sel; ifa.wbs_adr_i = adr; ifa.wbs_dat_i = dat;
    end else begin
      ifb.wbs_cyc_i = cyc; ifb.wbs_stb_i = cyc; ifb.wbs_we_i = we;
      ifb.wbs_sel_i = sel; ifb.wbs_adr_i = adr; ifb.wbs_dat_i = dat;
    end
  endtask
  task automatic wait_resp(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack_v[k] || err_v[k]) && n < 20000);
    check($sformatf("resp_timeout%0d", k), 72'(n < 20000), 72'd1);
    @(posedge clk); #1;
    drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask
  // mode 0: full access, mode 1: frames expected but response abandoned, mode 2: nothing expected
  task automatic req(input int k, input logic we, input logic [3:0] sel, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [71:0] resp, input bit exact, input int mode);
    logic ok;
    ok = resp[64] && !resp[65];
    if (exact) repeat (GAPC[k] + 8) @(posedge clk);
    @(posedge clk); #1;
    resp_val[k] = resp;
    if (mode < 2) begin
      exp_fr.push_back('{dut: k, frame: {we, 3'b000, sel, adr, we ? dat : 32'h0}});
      exp_fr.push_back('{dut: k, frame: 72'h0});
    end
    if (mode == 0) begin
      if (ok && !we) dat_model[k] = resp[31:0];
      exp_rs.push_back('{dut: k, is_ack: ok, dat: dat_model[k], t0: cycle,
                         lat: exact ? 2 + 290 * DIV[k] + GAPC[k] : -1});
    end
    drive(k, 1'b1, we, sel, adr, dat);
    if (mode == 0) wait_resp(k);
  endtask
  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done[0] < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("frame_wait", 72'(frames_done[0]), 72'(target));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n, seen, f0;
    logic [71:0] r;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    check("rst_cs_n", cs_a, 1'b1);
    check("rst_sclk", sclk_a, 1'b0);
    check("rst_mosi", mosi_a, 1'b0);
    check("rst_ack", ifa.wbs_ack_o, 1'b0);
    check("rst_err", ifa.wbs_err_o, 1'b0);
    check("rst_dat", ifa.wbs_dat_o, 32'h0);
    for (int i = 0; i < 3; i++)
      req(1, 1'b1, 4'($urandom), $urandom, $urandom, {6'h0, 2'b01, $urandom, $urandom}, i == 0, 0);
    check("b_frames", 72'(frames_done[1]), 72'd6);
    req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 72'h01_0000_0000_0000_0000, 1'b1, 0);
    req(0, 1'b0, 4'hF, 32'h24, 32'h1234_5678, 72'h01_0000_0000_CAFE_F00D, 1'b1, 0);
    req(0, 1'b0, 4'hF, 32'h28, 32'h0, 72'h02_0000_0000_1111_2222, 1'b1, 0);
    req(0, 1'b0, 4'hF, 32'h2C, 32'h0, 72'h00_0000_0000_3333_4444, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      r = {8'($urandom), $urandom, $urandom};
      req(0, 1'($urandom), 4'($urandom), $urandom, $urandom, r, 1'b1, 0);
    end
    req(0, 1'b1, 4'h3, 32'h44, 32'h5555_AAAA, 72'h01_0000_0000_0000_0000, 1'b1, 2);
    n = 0;
    while (rises[0] != 30 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("rise30_wait", 72'(rises[0]), 72'd30);
    #2 rst_n = 1'b0;
    seen = resp_seen[0];
    #1;
    check("abort_cs_n", cs_a, 1'b1);
    check("abort_sclk", sclk_a, 1'b0);
    check("abort_ack", ifa.wbs_ack_o, 1'b0);
    check("abort_err", ifa.wbs_err_o, 1'b0);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    dat_model[0] = 32'h0;
    repeat (40) @(posedge clk);
    check("abort_no_resp", 72'(resp_seen[0]), 72'(seen));
    req(0, 1'b1, 4'hC, 32'h48, 32'h0BAD_F00D, 72'h01_0000_0000_0000_0000, 1'b1, 0);
    f0 = frames_done[0];
    req(0, 1'b1, 4'hF, 32'h50, 32'h7777_8888, 72'h01_0000_0000_0000_0000, 1'b1, 1);
    wait_frames(f0 + 1);
    repeat (3) @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    seen = resp_seen[0];
    wait_frames(f0 + 2);
    repeat (4) @(posedge clk);
    check("drop_no_resp", 72'(resp_seen[0]), 72'(seen));
    req(0, 1'b1, 4'hF, 32'h54, 32'h9999_0000, 72'h01_0000_0000_0000_0000, 1'b0, 0);
    repeat (50) @(posedge clk);
    check("frames_left", 72'(exp_fr.size()), 72'd0);
    check("resps_left", 72'(exp_rs.size()), 72'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
